// File: rtl/consmax_lut_loader.sv
// -----------------------------------------------------------------------------
// consmax_lut_loader
//
// Purpose:
//   Sequencer that programs the two-bank ConSmax LUT from a byte stream coming
//   off the SPI configuration path. Byte pairs are packed little-endian into
//   16-bit FP words (1 sign, 8 exponent, 7 mantissa) and written one entry per
//   write strobe: bank0 entries 0..LUT_DEPTH-1, then bank1 entries
//   0..LUT_DEPTH-1. The consmax datapath ignores reads while lut_wen is high,
//   so dp_hold stalls its feed for the whole load.
//
// Optional feature (macro CONSMAX_LUT_CHECKSUM_EN):
//   When defined, an 8-bit running sum of every data byte is kept. After the
//   last word, one extra checksum byte is accepted. chk_err is raised when
//   (sum + checksum byte) mod 256 is non-zero. The LUT is written either way;
//   chk_err is advisory and stays set until the next cfg_start.
//   When undefined, there is no checksum state and chk_err is tied to 0.
//
// Ports:
//   clk        in   1            clock
//   rstn       in   1            synchronous active-low reset
//   cfg_start  in   1            start-load pulse (ignored while busy)
//   cfg_abort  in   1            abort-load pulse (ignored in IDLE/DONE)
//   in_data    in   8            config byte
//   in_valid   in   1            in_data valid
//   in_ready   out  1            loader can accept a byte
//   lut_waddr  out  LUT_ADDR+1   MSB = bank select, LSBs = entry index
//   lut_wen    out  1            LUT write strobe, one cycle per word
//   lut_wdata  out  LUT_DATA     packed FP word
//   dp_hold    out  1            stall request to the consmax datapath feed
//   busy       out  1            load in progress
//   done       out  1            one-cycle pulse when a load completes
//   chk_err    out  1            checksum mismatch, sticky until next start
// -----------------------------------------------------------------------------
module consmax_lut_loader #(
  parameter int IDATA_BIT = 8,
  parameter int LUT_DATA  = 16,
  parameter int LUT_ADDR  = IDATA_BIT >> 1,
  parameter int LUT_DEPTH = 2 ** LUT_ADDR
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [LUT_ADDR:0]   lut_waddr,
  output logic                lut_wen,
  output logic [LUT_DATA-1:0] lut_wdata,
  output logic                dp_hold,
  output logic                busy,
  output logic                done,
  output logic                chk_err
);

  // Word counter spans both banks; its MSB is the bank select.
  localparam int              LAST_WORD_I = 2 * LUT_DEPTH - 1;
  localparam logic [LUT_ADDR:0] WCNT_LAST = LAST_WORD_I[LUT_ADDR:0];
  localparam logic [LUT_ADDR:0] WCNT_ONE  = {{LUT_ADDR{1'b0}}, 1'b1};
  localparam logic [LUT_ADDR:0] WCNT_ZERO = {(LUT_ADDR+1){1'b0}};

`ifdef CONSMAX_LUT_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd5
  } state_t;
`endif

  // Modular byte sum used for the checksum accumulator.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    sum8 = a + b;
  endfunction

  state_t                state_r;
  state_t                state_nx_s;
  logic [LUT_ADDR:0]     wcnt_r;
  logic [LUT_ADDR:0]     wcnt_nx_s;
  logic [7:0]            lo_r;
  logic [7:0]            lo_nx_s;
  logic [LUT_ADDR:0]     waddr_r;
  logic [LUT_ADDR:0]     waddr_nx_s;
  logic [LUT_DATA-1:0]   wdata_r;
  logic [LUT_DATA-1:0]   wdata_nx_s;
  logic                  in_ready_r;
  logic                  lut_wen_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  xfer_s;
`ifdef CONSMAX_LUT_CHECKSUM_EN
  logic [7:0]            sum_r;
  logic [7:0]            sum_nx_s;
  logic                  chk_err_r;
  logic                  chk_err_nx_s;
`endif

  // in_ready_r already reflects LO/HI(/CHK), so this is a true handshake.
  assign xfer_s = in_valid & in_ready_r;

  // Next-state and datapath register updates for the load sequencer.
  always_comb begin
    state_nx_s = state_r;
    wcnt_nx_s  = wcnt_r;
    lo_nx_s    = lo_r;
    waddr_nx_s = waddr_r;
    wdata_nx_s = wdata_r;
`ifdef CONSMAX_LUT_CHECKSUM_EN
    sum_nx_s     = sum_r;
    chk_err_nx_s = chk_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Abort is meaningless here, so a simultaneous start still launches.
        if (cfg_start) begin
          state_nx_s = ST_LO;
          wcnt_nx_s  = WCNT_ZERO;
`ifdef CONSMAX_LUT_CHECKSUM_EN
          sum_nx_s     = 8'h00;
          chk_err_nx_s = 1'b0;
`endif
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (cfg_abort) begin
          state_nx_s = ST_IDLE;
          lo_nx_s    = 8'h00;
        end else if (xfer_s) begin
          lo_nx_s    = in_data;
          state_nx_s = ST_HI;
`ifdef CONSMAX_LUT_CHECKSUM_EN
          sum_nx_s = sum8(sum_r, in_data);
`endif
        end else begin
          state_nx_s = ST_LO;
        end
      end
      ST_HI: begin
        if (cfg_abort) begin
          // Drop the half-assembled word.
          state_nx_s = ST_IDLE;
          lo_nx_s    = 8'h00;
        end else if (xfer_s) begin
          wdata_nx_s = LUT_DATA'({in_data, lo_r});
          waddr_nx_s = wcnt_r;
          state_nx_s = ST_WR;
`ifdef CONSMAX_LUT_CHECKSUM_EN
          sum_nx_s = sum8(sum_r, in_data);
`endif
        end else begin
          state_nx_s = ST_HI;
        end
      end
      ST_WR: begin
        // Terminal compare precedes the increment so wcnt never wraps.
        if (cfg_abort) begin
          state_nx_s = ST_IDLE;
        end else if (wcnt_r == WCNT_LAST) begin
`ifdef CONSMAX_LUT_CHECKSUM_EN
          state_nx_s = ST_CHK;
`else
          state_nx_s = ST_DONE;
`endif
        end else begin
          wcnt_nx_s  = wcnt_r + WCNT_ONE;
          state_nx_s = ST_LO;
        end
      end
`ifdef CONSMAX_LUT_CHECKSUM_EN
      ST_CHK: begin
        if (cfg_abort) begin
          state_nx_s = ST_IDLE;
        end else if (xfer_s) begin
          chk_err_nx_s = (sum8(sum_r, in_data) != 8'h00);
          state_nx_s   = ST_DONE;
        end else begin
          state_nx_s = ST_CHK;
        end
      end
`endif
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath registers and outputs; outputs are decoded from the next state
  // so each one lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt_r     <= WCNT_ZERO;
      lo_r       <= 8'h00;
      waddr_r    <= WCNT_ZERO;
      wdata_r    <= {LUT_DATA{1'b0}};
      in_ready_r <= 1'b0;
      lut_wen_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      wcnt_r     <= wcnt_nx_s;
      lo_r       <= lo_nx_s;
      waddr_r    <= waddr_nx_s;
      wdata_r    <= wdata_nx_s;
`ifdef CONSMAX_LUT_CHECKSUM_EN
      in_ready_r <= (state_nx_s == ST_LO) || (state_nx_s == ST_HI) || (state_nx_s == ST_CHK);
`else
      in_ready_r <= (state_nx_s == ST_LO) || (state_nx_s == ST_HI);
`endif
      lut_wen_r  <= (state_nx_s == ST_WR);
      busy_r     <= (state_nx_s != ST_IDLE);
      done_r     <= (state_nx_s == ST_DONE);
    end
  end

`ifdef CONSMAX_LUT_CHECKSUM_EN
  // Checksum accumulator and sticky mismatch flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_r     <= 8'h00;
      chk_err_r <= 1'b0;
    end else begin
      sum_r     <= sum_nx_s;
      chk_err_r <= chk_err_nx_s;
    end
  end

  assign chk_err = chk_err_r;
`else
  assign chk_err = 1'b0;
`endif

  // DONE lasts one cycle after the final write, so dp_hold (= busy) covers
  // the datapath's registered copy of lut_wen.
  assign in_ready  = in_ready_r;
  assign lut_wen   = lut_wen_r;
  assign lut_waddr = waddr_r;
  assign lut_wdata = wdata_r;
  assign busy      = busy_r;
  assign dp_hold   = busy_r;
  assign done      = done_r;

endmodule
